// File: rtl/max_finder_pkg.sv
// rtl/max_finder_pkg.sv - shared state type and sizing helper for the arg-max finder
package max_finder_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/max_capture_bank.sv
// rtl/max_capture_bank.sv - per-lane capture registers and arrival mask
module max_capture_bank #(
    parameter int NUM_INPUT  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture_en,
    input  logic                            clear_mask,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] data,
    input  logic [NUM_INPUT-1:0]            data_valid,
    input  logic [IDX_WIDTH-1:0]            rd_ptr,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [DATA_WIDTH-1:0]           lane0_next,
    output logic                            mask_full
);

    logic [DATA_WIDTH-1:0] lanes [NUM_INPUT];
    logic [NUM_INPUT-1:0]  mask;
    logic [NUM_INPUT-1:0]  capture;

    assign capture   = capture_en ? data_valid : '0;
    assign mask_full = &(mask | capture);
    assign rd_data   = lanes[rd_ptr];

    // Lane 0 bypass: the scan seeds its running max on the same edge lane 0 may be captured.
    assign lane0_next = capture[0] ? data[DATA_WIDTH-1:0] : lanes[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            for (int k = 0; k < NUM_INPUT; k++) begin
                lanes[k] <= '0;
            end
        end else begin
            if (clear_mask) begin
                mask <= '0;
            end else begin
                mask <= mask | capture;
            end
            for (int k = 0; k < NUM_INPUT; k++) begin
                if (capture[k]) begin
                    lanes[k] <= data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/max_finder.sv
// rtl/max_finder.sv - collects neuron lanes, scans for the signed arg-max, hands off the class
module max_finder
    import max_finder_pkg::*;
#(
    parameter int  NUM_INPUT  = 10,
    parameter int  DATA_WIDTH = 16,
    localparam int IDX_WIDTH  = clog2_min1(NUM_INPUT)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_INPUT-1:0]            i_data_valid,
    input  logic                            i_class_ready,
    output logic [IDX_WIDTH-1:0]            o_class,
    output logic [DATA_WIDTH-1:0]           o_max_value,
    output logic                            o_class_valid,
    output logic                            o_busy,
    output logic                            o_overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST_PTR = IDX_WIDTH'(NUM_INPUT - 1);

    state_t                        state;
    logic [IDX_WIDTH-1:0]          ptr;
    logic [IDX_WIDTH-1:0]          idx_r;
    logic signed [DATA_WIDTH-1:0]  max_r;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic [DATA_WIDTH-1:0]         lane0_next;
    logic                          mask_full;
    logic                          cand_gt;
    logic                          accept;

    assign accept  = (state == HOLD) && o_class_valid && i_class_ready;
    assign cand_gt = $signed(rd_data) > max_r;

    max_capture_bank #(
        .NUM_INPUT  (NUM_INPUT),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk        (i_clk),
        .rst        (i_reset),
        .capture_en (state == COLLECT),
        .clear_mask (accept),
        .data       (i_data),
        .data_valid (i_data_valid),
        .rd_ptr     (ptr),
        .rd_data    (rd_data),
        .lane0_next (lane0_next),
        .mask_full  (mask_full)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= COLLECT;
            ptr           <= '0;
            idx_r         <= '0;
            max_r         <= '0;
            o_class       <= '0;
            o_max_value   <= '0;
            o_class_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            if ((state != COLLECT) && (|i_data_valid)) begin
                o_overrun <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (mask_full) begin
                        max_r  <= lane0_next;
                        idx_r  <= '0;
                        ptr    <= IDX_WIDTH'(1);
                        state  <= (NUM_INPUT == 1) ? HOLD : SCAN;
                        o_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strict greater-than so ties keep the lower index.
                    if (cand_gt) begin
                        max_r <= rd_data;
                        idx_r <= ptr;
                    end
                    if (ptr == LAST_PTR) begin
                        ptr   <= '0;
                        state <= HOLD;
                    end else begin
                        ptr <= ptr + IDX_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (!o_class_valid) begin
                        o_class_valid <= 1'b1;
                        o_class       <= idx_r;
                        o_max_value   <= max_r;
                    end else if (i_class_ready) begin
                        o_class_valid <= 1'b0;
                        state         <= COLLECT;
                        o_busy        <= 1'b0;
                    end
                end
                default: begin
                    state  <= COLLECT;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_finder.sv
// tb/tb_max_finder.sv - table-driven and directed-sequence bench for max_finder
module tb_max_finder;

    logic         clk;
    logic         rst;
    logic [159:0] data;
    logic [9:0]   dv;
    logic         ready;
    logic [3:0]   o_class;
    logic [15:0]  o_max;
    logic         cv;
    logic         busy;
    logic         ovr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [159:0] frame;
        logic [3:0]   exp_class;
        logic [15:0]  exp_max;
    } vec_t;

    vec_t vecs [8];

    max_finder dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_data        (data),
        .i_data_valid  (dv),
        .i_class_ready (ready),
        .o_class       (o_class),
        .o_max_value   (o_max),
        .o_class_valid (cv),
        .o_busy        (busy),
        .o_overrun     (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [159:0] mk(input logic [15:0] base, input int l1, input logic [15:0] v1,
                                        input int l2, input logic [15:0] v2);
        logic [159:0] f;
        for (int k = 0; k < 10; k++) f[k*16 +: 16] = base;
        if (l1 >= 0) f[l1*16 +: 16] = v1;
        if (l2 >= 0) f[l2*16 +: 16] = v2;
        return f;
    endfunction

    task automatic send_frame(input logic [159:0] f);
        data = f;
        dv   = '1;
        tick();
        dv   = '0;
    endtask

    // Counts edges after the capture edge until the result appears (bounded).
    task automatic wait_result(input string name, output int lat);
        lat = 0;
        while (!cv && lat < 40) begin
            tick();
            lat++;
        end
        if (!cv) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: got no o_class_valid after %0d cycles expected 10", name, lat);
        end
    endtask

    task automatic accept();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        int    lat;
        bit    stable;
        int    sched [10];

        vecs[0] = '{mk(16'h0010, 7, 16'h0400, -1, 16'h0), 4'd7, 16'h0400};
        vecs[1] = '{mk(16'hFFFB, 3, 16'hFFFF, -1, 16'h0), 4'd3, 16'hFFFF};
        vecs[2] = '{mk(16'h0000, 2, 16'h0200, 5, 16'h0200), 4'd2, 16'h0200};
        vecs[3] = '{mk(16'h1234, -1, 16'h0, -1, 16'h0), 4'd0, 16'h1234};
        vecs[4] = '{mk(16'h8000, 0, 16'h7FFF, -1, 16'h0), 4'd0, 16'h7FFF};
        vecs[5] = '{mk(16'h8000, 9, 16'h7FFF, -1, 16'h0), 4'd9, 16'h7FFF};
        vecs[6] = '{mk(16'h8000, 8, 16'h8001, -1, 16'h0), 4'd8, 16'h8001};
        vecs[7] = '{mk(16'hFFFF, 4, 16'h0001, -1, 16'h0), 4'd4, 16'h0001};

        // Reset with random inputs
        rst   = 1'b1;
        ready = $urandom_range(0, 1);
        dv    = 10'($urandom);
        data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        chk("rst_class", 32'(o_class), 32'd0);
        chk("rst_max", 32'(o_max), 32'd0);
        chk("rst_valid", 32'(cv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
        dv    = '0;
        ready = 1'b0;
        rst   = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Table: all lanes valid in one cycle
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].frame);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_result($sformatf("v%0d", i), lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd10);
            chk($sformatf("v%0d_class", i), 32'(o_class), 32'(vecs[i].exp_class));
            chk($sformatf("v%0d_max", i), 32'(o_max), 32'(vecs[i].exp_max));
            accept();
            chk($sformatf("v%0d_valid_drop", i), 32'(cv), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end
        chk("no_overrun_yet", 32'(ovr), 32'd0);

        // Staggered arrivals over 15 cycles, all negative
        sched = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 14};
        data  = vecs[1].frame;
        for (int c = 0; c < 15; c++) begin
            dv = '0;
            for (int k = 0; k < 10; k++) if (sched[k] == c) dv[k] = 1'b1;
            if (c == 14) chk("stagger_not_busy", 32'(busy), 32'd0);
            tick();
        end
        dv = '0;
        wait_result("stagger", lat);
        chk("stagger_latency", 32'(lat), 32'd10);
        chk("stagger_class", 32'(o_class), 32'd3);
        chk("stagger_max", 32'(o_max), 32'hFFFF);
        accept();

        // Tie, then repeat pulse on lane 2 lowers it
        data = mk(16'h0000, 2, 16'h0200, 5, 16'h0200);
        dv   = 10'h1FF;
        tick();
        data = mk(16'h0000, 2, 16'h0100, 5, 16'h0200);
        dv   = 10'h004;
        tick();
        dv   = 10'h200;
        tick();
        dv   = '0;
        wait_result("repeat", lat);
        chk("repeat_latency", 32'(lat), 32'd10);
        chk("repeat_class", 32'(o_class), 32'd5);
        chk("repeat_max", 32'(o_max), 32'h0200);
        chk("repeat_no_overrun", 32'(ovr), 32'd0);
        accept();

        // Backpressure with an overrun pulse in HOLD
        send_frame(vecs[0].frame);
        wait_result("bp", lat);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                data = mk(16'h7FFF, -1, 16'h0, -1, 16'h0);
                dv   = 10'h001;
            end else begin
                dv = '0;
            end
            tick();
            if (!(cv && o_class == 4'd7 && o_max == 16'h0400 && busy)) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_overrun", 32'(ovr), 32'd1);
        // Handover pulses must be dropped
        data  = mk(16'h7000, -1, 16'h0, -1, 16'h0);
        dv    = '1;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        dv    = '0;
        chk("bp_valid_drop", 32'(cv), 32'd0);
        chk("bp_class_kept", 32'(o_class), 32'd7);
        chk("bp_max_kept", 32'(o_max), 32'h0400);
        repeat (3) tick();
        chk("handover_dropped", 32'(busy), 32'd0);
        send_frame(mk(16'h0010, 4, 16'h0300, -1, 16'h0));
        wait_result("after_bp", lat);
        chk("after_bp_class", 32'(o_class), 32'd4);
        chk("after_bp_max", 32'(o_max), 32'h0300);
        chk("overrun_sticky", 32'(ovr), 32'd1);
        accept();

        // Reset during SCAN
        send_frame(vecs[0].frame);
        repeat (4) tick();
        chk("midscan_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_class", 32'(o_class), 32'd0);
        chk("midrst_max", 32'(o_max), 32'd0);
        chk("midrst_valid", 32'(cv), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(ovr), 32'd0);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("no_partial_result", 32'(cv), 32'd0);
        send_frame(mk(16'h0010, 9, 16'h0500, -1, 16'h0));
        wait_result("fresh", lat);
        chk("fresh_latency", 32'(lat), 32'd10);
        chk("fresh_class", 32'(o_class), 32'd9);
        chk("fresh_max", 32'(o_max), 32'h0500);
        accept();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_finder.md
Name: max_finder

Overview:
- Sits directly downstream of the final neuron layer (10 neurons, one per digit class).
- Collects the parallel per-neuron outputs, whose valid pulses may arrive on different cycles.
- Once all lanes are captured, performs a sequential signed arg-max scan, one lane per cycle.
- Presents the winning class index and its value on a valid/ready handshake to the result/readout logic.

Parameters:
NUM_INPUT, 10, number of neuron lanes consumed (>=1)
DATA_WIDTH, 16, width of each lane, two's-complement signed fixed point
IDX_WIDTH, derived localparam = max(1, clog2(NUM_INPUT)), width of class index

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_data  input  NUM_INPUT*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
i_data_valid  input  NUM_INPUT  per-lane single-cycle valid pulse
i_class_ready  input  1  consumer accepts result
o_class  output  IDX_WIDTH  index of maximum lane
o_max_value  output  DATA_WIDTH  value of maximum lane
o_class_valid  output  1  result valid, held until accepted
o_busy  output  1  high in SCAN or HOLD
o_overrun  output  1  sticky, set when a lane valid arrives outside COLLECT

Behaviour:
- Reset is asynchronous and active-high. It clears all lane registers, the capture mask, o_class, o_max_value, o_class_valid, o_busy and o_overrun to 0, and sets the state to COLLECT.
- States: COLLECT, SCAN, HOLD.
- COLLECT:
  - Any lane with i_data_valid[k]=1 latches i_data lane k and sets mask[k].
  - A repeat pulse on an already-set lane overwrites its data, with no error.
  - Several lanes may pulse in the same cycle.
  - When the mask including this cycle's pulses is all ones (capture edge T), go to SCAN.
  - On that same edge: max<=lane0, idx<=0, ptr<=1.
  - If NUM_INPUT=1, go directly to HOLD instead.
- SCAN:
  - Each cycle compares lane[ptr] > max, signed and strict, then ptr++.
  - If greater: max<=lane[ptr], idx<=ptr.
  - Ties keep the lower index.
  - The compare at ptr=NUM_INPUT-1 transitions to HOLD, so SCAN lasts NUM_INPUT-1 cycles.
- HOLD:
  - o_class_valid=1; o_class and o_max_value equal the registered idx and max.
  - o_class_valid rises on edge T+NUM_INPUT (10 cycles after the capture edge by default).
  - Outputs stay stable while i_class_ready=0.
  - On o_class_valid & i_class_ready: o_class_valid<=0, mask cleared, state to COLLECT. o_class and o_max_value retain their last values.
- o_busy = state != COLLECT, registered with the state.
- Any i_data_valid bit high in SCAN or HOLD: the pulse is dropped, lane data is not modified, and o_overrun<=1 until reset.
- Handover: pulses in the same cycle as the HOLD->COLLECT handshake are dropped and flagged as overrun. Capture of the next frame begins the following cycle.
- Reset mid-SCAN or mid-HOLD: immediate return to reset values. No partial result is emitted.
- Comparison arithmetic: DATA_WIDTH-bit signed, no extension needed, and no overflow is possible.

Decomposition:
- Package max_finder_pkg holds:
  - the state enum typedef (COLLECT, SCAN, HOLD);
  - a clog2-with-minimum-1 function for IDX_WIDTH.
- One sub-module, max_capture_bank: lane registers plus capture mask, exposing mask_full and a read port indexed by ptr.
- The FSM and comparator stay in max_finder.

Test Plan:
1. Reset asserted with random inputs -> o_class=0, o_max_value=0, o_class_valid=0, o_busy=0, o_overrun=0. Release -> COLLECT.
2. All 10 valids in one cycle; lane7=0x0400, others 0x0010 -> exactly 10 cycles later o_class_valid=1, o_class=7, o_max_value=0x0400.
3. Valids staggered over 15 cycles; all lanes negative, lane3=0xFFFF (-1), others 0xFFFB (-5) -> o_class=3, o_max_value=0xFFFF; valid rises 10 cycles after the last lane's capture.
4. Ties: lanes 2 and 5 both 0x0200 (the maximum) -> o_class=2. A repeat pulse on lane 2 with 0x0100 before completion -> o_class=5.
5. Backpressure: i_class_ready=0 for 20 cycles -> outputs stable. Lane-0 pulse during HOLD -> o_overrun=1, result unchanged. Ready=1 -> o_class_valid=0 next cycle; the next frame is processed correctly.
6. Reset asserted 4 cycles into SCAN -> all outputs 0 immediately. A fresh frame with lane9 as maximum -> o_class=9.
